// File: rtl/id_ex_stage_pkg.sv
// Shared widths and the control bundle carried from decode into execute.
// Also the helper that turns a decoded control bundle into a bubble.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 2;
    localparam int ALU_OP_W   = 4;
    localparam int BCNT_W     = 16;

    localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // A slot without a real instruction must carry no side effects.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic keep);
        ctrl_t r;
        r = keep ? c : '0;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the decode slot.
// Latency: combinational. Backpressure: none, result feeds the stage's own stall.
// Only sources the instruction actually consumes can raise the hazard.
module load_use_detect #(
    parameter int ADDR_W = 2
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic              id_valid,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [ADDR_W-1:0] id_read1,
    input  logic [ADDR_W-1:0] id_read2,
    output logic              hazard
);

    logic src_match;

    always_comb begin
        src_match = (id_use1 && (id_read1 == ex_dest)) ||
                    (id_use2 && (id_read2 == ex_dest));
        hazard    = ex_valid && ex_mem_read && ex_reg_write && id_valid && src_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Latency: one cycle. Backpressure: stall_in holds all state; hazard_stall holds IF/ID.
// Priority per edge: flush, then stall_in, then hazard bubble, then normal load.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   in_read1,
    input  logic [ADDR_W-1:0]   in_read2,
    input  logic                in_use1,
    input  logic                in_use2,
    input  logic [DATA_W-1:0]   in_rs1_data,
    input  logic [DATA_W-1:0]   in_rs2_data,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [ADDR_W-1:0]   in_dest,
    input  logic                in_reg_write,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [ALU_OP_W-1:0] in_alu_op,
    input  logic                stall_in,
    input  logic                flush,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_rs1_data,
    output logic [DATA_W-1:0]   out_rs2_data,
    output logic [DATA_W-1:0]   out_imm,
    output logic [DATA_W-1:0]   out_pc,
    output logic [ADDR_W-1:0]   out_dest,
    output logic [ADDR_W-1:0]   out_read1,
    output logic [ADDR_W-1:0]   out_read2,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                hazard_stall,
    output logic [BCNT_W-1:0]   bubble_count
);

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    ctrl_t             in_ctrl;
    logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d;
    logic [ADDR_W-1:0] dest_q, dest_d, read1_q, read1_d, read2_q, read2_d;
    logic [BCNT_W-1:0] bubble_count_q, bubble_count_d;
    logic              bubble_inc;
    logic              hazard;

    load_use_detect #(
        .ADDR_W (ADDR_W)
    ) u_load_use_detect (
        .ex_valid     (valid_q),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_reg_write (ctrl_q.reg_write),
        .ex_dest      (dest_q),
        .id_valid     (in_valid),
        .id_use1      (in_use1),
        .id_use2      (in_use2),
        .id_read1     (in_read1),
        .id_read2     (in_read2),
        .hazard       (hazard)
    );

    always_comb begin
        in_ctrl.reg_write = in_reg_write;
        in_ctrl.mem_read  = in_mem_read;
        in_ctrl.mem_write = in_mem_write;
        in_ctrl.alu_op    = in_alu_op;

        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        dest_d     = dest_q;
        read1_d    = read1_q;
        read2_d    = read2_q;
        bubble_inc = 1'b0;

        if (flush) begin
            // A squash only counts as a bubble when it kills a live instruction.
            valid_d    = 1'b0;
            ctrl_d     = '0;
            bubble_inc = valid_q;
        end else if (!stall_in) begin
            if (hazard) begin
                valid_d    = 1'b0;
                ctrl_d     = '0;
                bubble_inc = 1'b1;
            end else begin
                valid_d = in_valid;
                ctrl_d  = ctrl_gate(in_ctrl, in_valid);
                rs1_d   = in_rs1_data;
                rs2_d   = in_rs2_data;
                imm_d   = in_imm;
                pc_d    = in_pc;
                dest_d  = in_dest;
                read1_d = in_read1;
                read2_d = in_read2;
            end
        end

        bubble_count_d = bubble_count_q;
        if (bubble_inc && (bubble_count_q != BCNT_MAX)) begin
            bubble_count_d = bubble_count_q + {{(BCNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= 1'b0;
            ctrl_q         <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            dest_q         <= '0;
            read1_q        <= '0;
            read2_q        <= '0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            ctrl_q         <= ctrl_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            imm_q          <= imm_d;
            pc_q           <= pc_d;
            dest_q         <= dest_d;
            read1_q        <= read1_d;
            read2_q        <= read2_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    always_comb begin
        out_valid     = valid_q;
        out_rs1_data  = rs1_q;
        out_rs2_data  = rs2_q;
        out_imm       = imm_q;
        out_pc        = pc_q;
        out_dest      = dest_q;
        out_read1     = read1_q;
        out_read2     = read2_q;
        out_reg_write = ctrl_q.reg_write;
        out_mem_read  = ctrl_q.mem_read;
        out_mem_write = ctrl_q.mem_write;
        out_alu_op    = ctrl_q.alu_op;
        hazard_stall  = hazard;
        bubble_count  = bubble_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: each cycle's expected visible state is queued
// by the driver and checked by an independent monitor just after inputs settle.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_use1, in_use2, in_reg_write, in_mem_read, in_mem_write;
    logic [1:0]  in_read1, in_read2, in_dest;
    logic [15:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic [3:0]  in_alu_op;
    logic        stall_in, flush;
    logic        out_valid, out_reg_write, out_mem_read, out_mem_write, hazard_stall;
    logic [15:0] out_rs1_data, out_rs2_data, out_imm, out_pc, bubble_count;
    logic [1:0]  out_dest, out_read1, out_read2;
    logic [3:0]  out_alu_op;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_read1(in_read1), .in_read2(in_read2),
        .in_use1(in_use1), .in_use2(in_use2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc), .in_dest(in_dest),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_alu_op(in_alu_op), .stall_in(stall_in), .flush(flush),
        .out_valid(out_valid), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_pc(out_pc), .out_dest(out_dest),
        .out_read1(out_read1), .out_read2(out_read2),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_alu_op(out_alu_op), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    typedef struct {
        logic        valid, u1, u2, rw, mr, mw;
        logic [1:0]  r1, r2, dest;
        logic [15:0] d1, d2, imm, pc;
        logic [3:0]  op;
    } in_t;

    typedef struct {
        string       name;
        logic        hz, chk_data, valid, rw, mr, mw;
        logic [1:0]  r1, r2, dest;
        logic [15:0] d1, d2, imm, pc, bc;
        logic [3:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic in_t mk(input logic v, input logic [1:0] r1, input logic u1,
                               input logic [1:0] r2, input logic u2,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] imm, input logic [15:0] pc,
                               input logic [1:0] dest, input logic rw, input logic mr,
                               input logic mw, input logic [3:0] op);
        in_t i;
        i.valid = v; i.r1 = r1; i.u1 = u1; i.r2 = r2; i.u2 = u2;
        i.d1 = d1; i.d2 = d2; i.imm = imm; i.pc = pc; i.dest = dest;
        i.rw = rw; i.mr = mr; i.mw = mw; i.op = op;
        return i;
    endfunction

    // Expected EX copy of a valid instruction that was loaded on the previous edge.
    function automatic exp_t e_ld(input string n, input in_t i, input logic hz, input logic [15:0] bc);
        exp_t e;
        e.name = n; e.hz = hz; e.chk_data = 1'b1; e.valid = 1'b1;
        e.rw = i.rw; e.mr = i.mr; e.mw = i.mw; e.r1 = i.r1; e.r2 = i.r2; e.dest = i.dest;
        e.d1 = i.d1; e.d2 = i.d2; e.imm = i.imm; e.pc = i.pc; e.op = i.op; e.bc = bc;
        return e;
    endfunction

    function automatic exp_t e_bub(input string n, input logic hz, input logic [15:0] bc);
        exp_t e;
        e = e_ld(n, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), hz, bc);
        e.valid = 1'b0; e.chk_data = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_zero(input string n);
        exp_t e;
        e = e_bub(n, 1'b0, 16'h0000);
        e.chk_data = 1'b1;
        return e;
    endfunction

    // rs: 0 = reset low, 1 = reset high from the start of the cycle, 2 = reset pulsed mid-cycle.
    task automatic step(input in_t i, input logic st, input logic fl, input int rs, input exp_t e);
        @(negedge clk);
        reset        = (rs == 1);
        in_valid     = i.valid; in_read1 = i.r1; in_read2 = i.r2;
        in_use1      = i.u1; in_use2 = i.u2;
        in_rs1_data  = i.d1; in_rs2_data = i.d2; in_imm = i.imm; in_pc = i.pc;
        in_dest      = i.dest; in_reg_write = i.rw; in_mem_read = i.mr; in_mem_write = i.mw;
        in_alu_op    = i.op; stall_in = st; flush = fl;
        sb.push_back(e);
        if (rs == 2) begin
            #1 reset = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = (hazard_stall !== e.hz) || (out_valid !== e.valid) ||
                      (out_reg_write !== e.rw) || (out_mem_read !== e.mr) ||
                      (out_mem_write !== e.mw) || (bubble_count !== e.bc);
                if (e.chk_data) begin
                    bad = bad || (out_rs1_data !== e.d1) || (out_rs2_data !== e.d2) ||
                          (out_imm !== e.imm) || (out_pc !== e.pc) || (out_dest !== e.dest) ||
                          (out_read1 !== e.r1) || (out_read2 !== e.r2) || (out_alu_op !== e.op);
                end
                n_vec++;
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s: got hz=%b v=%b rw/mr/mw=%b%b%b bc=%h d1=%h d2=%h imm=%h pc=%h dst=%0d r1=%0d r2=%0d op=%h | want hz=%b v=%b rw/mr/mw=%b%b%b bc=%h d1=%h d2=%h imm=%h pc=%h dst=%0d r1=%0d r2=%0d op=%h (data %s)",
                             e.name, hazard_stall, out_valid, out_reg_write, out_mem_read, out_mem_write,
                             bubble_count, out_rs1_data, out_rs2_data, out_imm, out_pc, out_dest,
                             out_read1, out_read2, out_alu_op,
                             e.hz, e.valid, e.rw, e.mr, e.mw, e.bc, e.d1, e.d2, e.imm, e.pc, e.dest,
                             e.r1, e.r2, e.op, e.chk_data ? "checked" : "ignored");
                end
            end
        end
    end

    initial begin : stimulus
        in_t idle, a, ld, b, c, d, sw, e1, e2, e3, e4;
        int  wait_cyc;
        idle = mk(0, 2'd2, 1, 2'd1, 1, 16'hDEAD, 16'hBEEF, 16'h0000, 16'h0000, 2'd1, 1, 1, 1, 4'hF);
        a    = mk(1, 2'd0, 1, 2'd3, 1, 16'h1234, 16'h00FF, 16'h0010, 16'h0100, 2'd2, 1, 0, 0, 4'd3);
        ld   = mk(1, 2'd0, 1, 2'd0, 0, 16'h0040, 16'h0000, 16'h0004, 16'h0102, 2'd1, 1, 1, 0, 4'd1);
        b    = mk(1, 2'd1, 1, 2'd2, 1, 16'h5555, 16'hAAAA, 16'h0000, 16'h0104, 2'd3, 1, 0, 0, 4'd2);
        c    = mk(1, 2'd1, 0, 2'd2, 1, 16'h1111, 16'h2222, 16'h0008, 16'h0106, 2'd3, 1, 0, 0, 4'd4);
        d    = mk(1, 2'd0, 1, 2'd1, 1, 16'h3333, 16'h4444, 16'hFFFC, 16'h0108, 2'd0, 1, 0, 0, 4'd5);
        sw   = mk(1, 2'd2, 1, 2'd3, 1, 16'h0010, 16'h0020, 16'h0008, 16'h010A, 2'd0, 0, 0, 1, 4'd6);
        e1   = mk(1, 2'd1, 1, 2'd2, 1, 16'hE001, 16'hF001, 16'h0001, 16'h0200, 2'd1, 1, 0, 0, 4'd7);
        e2   = mk(1, 2'd2, 1, 2'd3, 0, 16'hE002, 16'hF002, 16'h0002, 16'h0202, 2'd2, 1, 0, 0, 4'd8);
        e3   = mk(1, 2'd3, 0, 2'd0, 1, 16'hE003, 16'hF003, 16'h0003, 16'h0204, 2'd3, 0, 0, 1, 4'd9);
        e4   = mk(1, 2'd0, 1, 2'd1, 1, 16'hE004, 16'hF004, 16'h0004, 16'h0206, 2'd2, 1, 0, 0, 4'hA);

        reset = 1'b1;
        step(idle, 0, 0, 1, e_zero("reset_state"));
        step(a,    0, 0, 0, e_zero("post_reset_idle"));
        step(idle, 0, 0, 0, e_ld("normal_load", a, 0, 16'd0));
        step(ld,   0, 0, 0, e_bub("invalid_zeroes_ctrl", 0, 16'd0));
        step(b,    0, 0, 0, e_ld("load_use_use1", ld, 1, 16'd0));
        step(b,    0, 0, 0, e_bub("hazard_bubble", 0, 16'd1));
        step(ld,   0, 0, 0, e_ld("issue_after_bubble", b, 0, 16'd1));
        step(c,    0, 0, 0, e_ld("false_match_use1_0", ld, 0, 16'd1));
        step(ld,   0, 0, 0, e_ld("no_bubble_after_false", c, 0, 16'd1));
        step(d,    0, 0, 0, e_ld("load_use_use2", ld, 1, 16'd1));
        step(d,    0, 0, 0, e_bub("hazard_bubble_2", 0, 16'd2));
        step(sw,   0, 0, 0, e_ld("issue_d", d, 0, 16'd2));
        step(e1,   1, 0, 0, e_ld("stall_1", sw, 0, 16'd2));
        step(e2,   1, 0, 0, e_ld("stall_2", sw, 0, 16'd2));
        step(e3,   1, 0, 0, e_ld("stall_3", sw, 0, 16'd2));
        step(e4,   0, 0, 0, e_ld("stall_release", sw, 0, 16'd2));
        step(sw,   0, 0, 0, e_ld("capture_on_release", e4, 0, 16'd2));
        step(e1,   1, 0, 0, e_ld("sw_in_ex", sw, 0, 16'd2));
        step(e2,   1, 1, 0, e_ld("sw_held_flush", sw, 0, 16'd2));
        step(idle, 0, 1, 0, e_bub("flush_over_stall", 0, 16'd3));
        step(ld,   0, 0, 0, e_bub("flush_of_bubble_uncounted", 0, 16'd3));
        step(b,    1, 0, 0, e_ld("hazard_under_stall", ld, 1, 16'd3));
        step(b,    0, 0, 0, e_ld("hazard_after_stall", ld, 1, 16'd3));
        step(b,    0, 0, 0, e_bub("bubble_after_stall", 0, 16'd4));
        step(idle, 0, 0, 0, e_ld("issue_b_again", b, 0, 16'd4));
        step(idle, 0, 0, 0, e_bub("idle_slot", 0, 16'd4));

        @(posedge clk);
        #1 force dut.bubble_count_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.bubble_count_q;

        step(a,    0, 0, 0, e_bub("preset_fffe", 0, 16'hFFFE));
        step(c,    0, 1, 0, e_ld("a_before_flush1", a, 0, 16'hFFFE));
        step(a,    0, 0, 0, e_bub("sat_reach", 0, 16'hFFFF));
        step(c,    0, 1, 0, e_ld("a_before_flush2", a, 0, 16'hFFFF));
        step(idle, 0, 0, 0, e_bub("sat_hold", 0, 16'hFFFF));
        step(sw,   0, 0, 0, e_bub("sat_idle", 0, 16'hFFFF));
        step(e1,   1, 0, 0, e_ld("sw_held_pre_reset", sw, 0, 16'hFFFF));
        step(e2,   1, 0, 2, e_zero("async_reset_mid_cycle"));
        step(a,    0, 0, 0, e_zero("reset_released"));
        step(idle, 0, 0, 0, e_ld("load_after_reset", a, 0, 16'd0));

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        repeat (2) @(negedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
